// File: rtl/gray_to_rgb_mapper_if.sv
// rtl/gray_to_rgb_mapper_if.sv - pixel-in / rgb-out stream bundle for the colour mapper
interface gray_to_rgb_mapper_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] rgb_r;
    logic [PIX_W-1:0] rgb_g;
    logic [PIX_W-1:0] rgb_b;
    logic             out_sof;
    logic             out_eol;
    logic             out_eof;

    // master is the source/sink pair around the mapper, slave is the mapper itself
    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, rgb_r, rgb_g, rgb_b, out_sof, out_eol, out_eof
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, rgb_r, rgb_g, rgb_b, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/gray_to_rgb_mapper.sv
// rtl/gray_to_rgb_mapper.sv - streaming gray/binary pixel to RGB mapper with frame sideband
module gray_to_rgb_mapper #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int CNT_W  = 16,
    parameter int FCNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    gray_to_rgb_mapper_if.slave  px,
    input  logic [1:0]           cfg_mode,
    input  logic [PIX_W-1:0]     cfg_thresh,
    input  logic [3*PIX_W-1:0]   cfg_fg,
    input  logic [3*PIX_W-1:0]   cfg_bg,
    output logic [FCNT_W-1:0]    frame_cnt
);
    localparam logic [PIX_W-1:0] PIX_MAX  = '1;
    localparam logic [PIX_W-1:0] PIX_HALF = {1'b1, {(PIX_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        MODE_REPL   = 2'd0,
        MODE_THRESH = 2'd1,
        MODE_INV    = 2'd2,
        MODE_RAMP   = 2'd3
    } mode_e;

    logic                 out_valid_q, out_valid_d;
    logic [PIX_W-1:0]     rgb_r_q, rgb_r_d;
    logic [PIX_W-1:0]     rgb_g_q, rgb_g_d;
    logic [PIX_W-1:0]     rgb_b_q, rgb_b_d;
    logic                 sof_q, sof_d;
    logic                 eol_q, eol_d;
    logic                 eof_q, eof_d;
    logic [CNT_W-1:0]     col_q, col_d;
    logic [CNT_W-1:0]     row_q, row_d;
    logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    mode_e                mode_q, mode_d;
    logic [PIX_W-1:0]     thresh_q, thresh_d;
    logic [3*PIX_W-1:0]   fg_q, fg_d;
    logic [3*PIX_W-1:0]   bg_q, bg_d;

    logic                 in_ready_c;
    logic                 accept;
    logic                 frame_start;
    logic                 col_last;
    logic                 row_last;
    mode_e                mode_eff;
    logic [PIX_W-1:0]     thresh_eff;
    logic [3*PIX_W-1:0]   fg_eff;
    logic [3*PIX_W-1:0]   bg_eff;
    logic [PIX_W-1:0]     map_r, map_g, map_b;

    // Reset holds the input closed so nothing is accepted into a discarded frame
    always_comb begin
        in_ready_c  = rst && (!out_valid_q || px.out_ready);
        accept      = px.in_valid && in_ready_c;
        frame_start = (col_q == '0) && (row_q == '0);
        col_last    = (col_q == COL_LAST);
        row_last    = (row_q == ROW_LAST);
    end

    // The first pixel of a frame sees the live config; the rest see the latched copy
    always_comb begin
        if (frame_start) begin
            mode_eff   = mode_e'(cfg_mode);
            thresh_eff = cfg_thresh;
            fg_eff     = cfg_fg;
            bg_eff     = cfg_bg;
        end else begin
            mode_eff   = mode_q;
            thresh_eff = thresh_q;
            fg_eff     = fg_q;
            bg_eff     = bg_q;
        end
    end

    always_comb begin
        map_r = '0;
        map_g = '0;
        map_b = '0;
        case (mode_eff)
            MODE_REPL: begin
                map_r = px.in_pixel;
                map_g = px.in_pixel;
                map_b = px.in_pixel;
            end
            MODE_THRESH: begin
                if (px.in_pixel >= thresh_eff) begin
                    {map_r, map_g, map_b} = fg_eff;
                end else begin
                    {map_r, map_g, map_b} = bg_eff;
                end
            end
            MODE_INV: begin
                map_r = PIX_MAX - px.in_pixel;
                map_g = PIX_MAX - px.in_pixel;
                map_b = PIX_MAX - px.in_pixel;
            end
            MODE_RAMP: begin
                // Lower half ramps blue->green, upper half ramps green->red
                if (px.in_pixel < PIX_HALF) begin
                    map_r = '0;
                    map_g = px.in_pixel << 1;
                    map_b = PIX_MAX - map_g;
                end else begin
                    map_r = (px.in_pixel - PIX_HALF) << 1;
                    map_g = PIX_MAX - map_r;
                    map_b = '0;
                end
            end
            default: begin
                map_r = '0;
                map_g = '0;
                map_b = '0;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        rgb_r_d     = rgb_r_q;
        rgb_g_d     = rgb_g_q;
        rgb_b_d     = rgb_b_q;
        sof_d       = sof_q;
        eol_d       = eol_q;
        eof_d       = eof_q;
        col_d       = col_q;
        row_d       = row_q;
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        thresh_d    = thresh_q;
        fg_d        = fg_q;
        bg_d        = bg_q;

        if (accept) begin
            out_valid_d = 1'b1;
            rgb_r_d     = map_r;
            rgb_g_d     = map_g;
            rgb_b_d     = map_b;
            sof_d       = frame_start;
            eol_d       = col_last;
            eof_d       = col_last && row_last;

            if (frame_start) begin
                mode_d   = mode_e'(cfg_mode);
                thresh_d = cfg_thresh;
                fg_d     = cfg_fg;
                bg_d     = cfg_bg;
            end

            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d       = '0;
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                end else begin
                    row_d = row_q + CNT_W'(1);
                end
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end else if (px.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            rgb_r_q     <= '0;
            rgb_g_q     <= '0;
            rgb_b_q     <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            frame_cnt_q <= '0;
            mode_q      <= MODE_REPL;
            thresh_q    <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rgb_r_q     <= rgb_r_d;
            rgb_g_q     <= rgb_g_d;
            rgb_b_q     <= rgb_b_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            thresh_q    <= thresh_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
        end
    end

    assign px.in_ready  = in_ready_c;
    assign px.out_valid = out_valid_q;
    assign px.rgb_r     = rgb_r_q;
    assign px.rgb_g     = rgb_g_q;
    assign px.rgb_b     = rgb_b_q;
    assign px.out_sof   = sof_q;
    assign px.out_eol   = eol_q;
    assign px.out_eof   = eof_q;
    assign frame_cnt    = frame_cnt_q;
endmodule
